// File: rtl/neuron_acc_ctrl_if.sv
// Beat stream from the weight/activation fetch logic into the neuron controller.
// The master drives a beat and in_valid; the slave returns in_ready.
interface neuron_acc_ctrl_if;
   logic in_valid;
   logic in_ready;
   logic x_bit;
   logic w_bit;
   logic mask;

   modport master (
      output in_valid,
      output x_bit,
      output w_bit,
      output mask,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  x_bit,
      input  w_bit,
      input  mask,
      output in_ready
   );
endinterface

// File: rtl/neuron_acc_ctrl.sv
// Binary-MLP neuron sequencer: counts N_IN accepted (x,w) beats, steers a -1/+1/0 mux
// into a signed accumulator and reports the sum and its sign.
//
//   state  | meaning
//   S_IDLE | waiting for start; result of last evaluation held
//   S_ACC  | accepting beats, in_ready high
//   S_DONE | one-cycle done pulse; acc and out_bit final
module neuron_acc_ctrl #(
   parameter int N_IN  = 32,
   parameter int ACC_W = 7
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   neuron_acc_ctrl_if.slave  s_in,
   output logic              o_sel1,
   output logic              o_sel0,
   output logic              o_busy,
   output logic              o_done,
   output logic [ACC_W-1:0]  o_acc,
   output logic              o_out_bit
);

   localparam int CNT_W = $clog2(N_IN + 1);
   localparam logic [ACC_W-1:0] C_IN10 = '1;
   localparam logic [ACC_W-1:0] C_IN01 = ACC_W'(1);
   localparam logic [ACC_W-1:0] C_IN00 = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_out_bit;
   logic               r_in_ready;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic               w_last;
   logic [1:0]         w_sel;
   logic [ACC_W-1:0]   w_mux_out;
   logic [ACC_W-1:0]   w_acc_nxt;

   assign w_accept = s_in.in_valid & r_in_ready;
   assign w_last   = w_accept && (r_cnt == CNT_W'(N_IN - 1));

   // select 11 is unreachable by construction
   always_comb begin
      w_sel = 2'b00;
      if (w_accept && !s_in.mask) begin
         if (s_in.x_bit ~^ s_in.w_bit) w_sel = 2'b01;
         else                          w_sel = 2'b10;
      end
   end

   always_comb begin
      w_mux_out = C_IN00;
      case (w_sel)
         2'b01:   w_mux_out = C_IN01;
         2'b10:   w_mux_out = C_IN10;
         default: w_mux_out = C_IN00;
      endcase
   end

   assign w_acc_nxt = r_acc + w_mux_out;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_out_bit  <= 1'b0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_out_bit  <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_ACC;
               end
            end
            S_ACC: begin
               if (w_accept) begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) begin
                     r_out_bit  <= ~w_acc_nxt[ACC_W-1];
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign s_in.in_ready = r_in_ready;
   assign o_sel1        = w_sel[1];
   assign o_sel0        = w_sel[0];
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_acc         = r_acc;
   assign o_out_bit     = r_out_bit;

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Randomized self-checking bench for neuron_acc_ctrl; expected sums come from a
// per-beat arithmetic model of the -1/+1/0 contribution rule.
module tb_neuron_acc_ctrl;
   localparam int N_IN = 32;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_start;
   logic       o_sel1, o_sel0, o_busy, o_done, o_out_bit;
   logic [6:0] o_acc;
   int         n_cmp = 0;
   int         n_bad = 0;

   neuron_acc_ctrl_if bif ();

   neuron_acc_ctrl #(.N_IN(N_IN), .ACC_W(7)) dut (
      .i_clk     (clk),
      .i_rst     (i_rst),
      .i_start   (i_start),
      .s_in      (bif.slave),
      .o_sel1    (o_sel1),
      .o_sel0    (o_sel0),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_acc     (o_acc),
      .o_out_bit (o_out_bit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int beat_val(input logic x, input logic w, input logic m);
      if (m) return 0;
      return (x == w) ? 1 : -1;
   endfunction

   // kind: 0 all match, 1 all mismatch, 2 alternating, 3 31 mismatch + 1 masked,
   //       4 16/16 shuffled, 5 fully random
   task automatic run_eval(input int kind, input int gap, input int start_beat,
                           input int rst_beat, input bit pulse_done);
      logic       xa[64], wa[64], ma[64];
      logic [6:0] ea;
      logic [1:0] es;
      int         beats = 0, sum = 0, phase = 1, cyc = 0, idx, j, mpos;
      bit         fin = 0, v;
      logic       t;

      mpos = $urandom_range(N_IN - 1);
      for (int i = 0; i < 64; i++) begin
         xa[i] = 1'($urandom);
         ma[i] = 1'b0;
         case (kind)
            0: wa[i] = xa[i];
            1: wa[i] = ~xa[i];
            2: wa[i] = (i % 2 == 0) ? xa[i] : ~xa[i];
            3: begin wa[i] = ~xa[i]; ma[i] = (i == mpos); end
            4: wa[i] = (i < 16) ? xa[i] : ~xa[i];
            default: begin wa[i] = 1'($urandom); ma[i] = ($urandom_range(3) == 0); end
         endcase
      end
      if (kind == 4) begin
         for (int i = N_IN - 1; i > 0; i--) begin
            j = $urandom_range(i);
            t = wa[i] ^ xa[i]; wa[i] = xa[i] ^ (wa[j] ^ xa[j]); wa[j] = xa[j] ^ t;
         end
      end

      @(posedge clk); #1;
      i_start = 1'b1;
      bif.in_valid = 1'b0;
      @(negedge clk);
      chk("start_cyc_busy", o_busy, 0);
      chk("start_cyc_ready", bif.in_ready, 0);

      while (!fin && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         i_start = 1'b0;
         if (phase == 1 && rst_beat >= 0 && beats == rst_beat) begin
            i_rst = 1'b1;
            bif.in_valid = 1'b1;
            @(posedge clk); #1;
            i_rst = 1'b0;
            @(negedge clk);
            chk("rst_busy", o_busy, 0);
            chk("rst_acc", o_acc, 0);
            chk("rst_done", o_done, 0);
            chk("rst_ready", bif.in_ready, 0);
            chk("rst_sel", {o_sel1, o_sel0}, 0);
            @(negedge clk);
            chk("rst_no_done", o_done, 0);
            return;
         end
         v = (phase == 1) ? ($urandom_range(99) >= gap) : 1'($urandom);
         if (phase == 1 && beats == start_beat) i_start = 1'b1;
         if (phase == 2 && pulse_done)          i_start = 1'b1;
         idx = (beats < 64) ? beats : 0;
         bif.in_valid = v;
         bif.x_bit = (phase == 1) ? xa[idx] : 1'($urandom);
         bif.w_bit = (phase == 1) ? wa[idx] : 1'($urandom);
         bif.mask  = (phase == 1) ? ma[idx] : 1'($urandom);
         @(negedge clk);
         ea = sum[6:0];
         case (phase)
            1: begin
               chk("acc_ready", bif.in_ready, 1);
               chk("acc_busy", o_busy, 1);
               chk("acc_done", o_done, 0);
               chk("acc_partial", o_acc, ea);
               if (!v)              es = 2'b00;
               else if (ma[idx])    es = 2'b00;
               else if (xa[idx] == wa[idx]) es = 2'b01;
               else                 es = 2'b10;
               chk(v ? "sel_beat" : "sel_gap", {o_sel1, o_sel0}, es);
               if (v) begin
                  sum += beat_val(xa[idx], wa[idx], ma[idx]);
                  beats++;
                  if (beats == N_IN) phase = 2;
               end
            end
            2: begin
               chk("done_pulse", o_done, 1);
               chk("done_busy", o_busy, 1);
               chk("done_ready", bif.in_ready, 0);
               chk("done_sel", {o_sel1, o_sel0}, 0);
               chk("done_acc", o_acc, ea);
               chk("done_out_bit", o_out_bit, (sum >= 0) ? 1 : 0);
               if (gap == 0) chk("done_latency", cyc, N_IN + 1);
               phase = 3;
            end
            default: begin
               chk("post_done", o_done, 0);
               chk("post_busy", o_busy, 0);
               chk("post_ready", bif.in_ready, 0);
               chk("post_sel", {o_sel1, o_sel0}, 0);
               chk("post_acc_hold", o_acc, ea);
               chk("post_out_hold", o_out_bit, (sum >= 0) ? 1 : 0);
               fin = 1;
            end
         endcase
      end
      if (!fin) chk("timeout", 0, 1);
   endtask

   initial begin
      i_rst = 1'b1;
      i_start = 1'b0;
      bif.in_valid = 1'b1;
      bif.x_bit = 1'b1;
      bif.w_bit = 1'b1;
      bif.mask = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_acc", o_acc, 0);
      chk("reset_busy", o_busy, 0);
      chk("reset_done", o_done, 0);
      chk("reset_ready", bif.in_ready, 0);
      chk("reset_out_bit", o_out_bit, 0);
      chk("reset_sel", {o_sel1, o_sel0}, 0);
      @(posedge clk); #1;
      i_rst = 1'b0;
      @(negedge clk);
      chk("idle_ignores_valid", {o_sel1, o_sel0}, 0);

      run_eval(0, 0, -1, -1, 1'b0);
      chk("all_match_acc", o_acc, 7'b0100000);
      run_eval(1, 0, -1, -1, 1'b0);
      chk("all_mismatch_acc", o_acc, 7'b1100000);
      run_eval(2, 0, -1, -1, 1'b0);
      run_eval(3, 0, -1, -1, 1'b0);
      chk("masked_acc", o_acc, 7'b1100001);
      run_eval(4, 50, -1, -1, 1'b0);
      chk("gap_acc", o_acc, 0);
      run_eval(4, 0, 10, -1, 1'b1);
      chk("start_ignored_acc", o_acc, 0);
      run_eval(5, 0, -1, 20, 1'b0);
      run_eval(0, 0, -1, -1, 1'b0);
      for (int r = 0; r < 4; r++)
         run_eval(5, $urandom_range(60), $urandom_range(N_IN - 1), -1, 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/neuron_acc_ctrl.md
# neuron_acc_ctrl

Sequencing controller for one binary-MLP neuron. It accepts a stream of (activation, weight) bit pairs through a valid/ready handshake and drives the select lines of an internal `mux_31`, which supplies −1, +1 or 0 to a signed accumulator. After exactly `N_IN` accepted beats it reports the popcount-style sum and its sign bit. It sits between the layer's weight/activation fetch logic and the next layer's activation buffer.

## Interface
- `N_IN`, 32: number of input beats per neuron evaluation; legal range 1..63.
- `ACC_W`, 7: accumulator width; fixed at 7 to match `mux_31` data width; two's complement.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begins a new evaluation; honoured only in IDLE.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: controller accepts a beat this cycle.
- `x_bit` input 1: activation bit (1 = +1, 0 = −1).
- `w_bit` input 1: weight bit (1 = +1, 0 = −1).
- `mask` input 1: beat is padding; contributes 0 but still counts.
- `sel1` output 1: `mux_31` select, MSB (observable copy).
- `sel0` output 1: `mux_31` select, LSB (observable copy).
- `busy` output 1: evaluation in progress (state ACC or DONE).
- `done` output 1: one-cycle pulse; result valid.
- `acc` output 7: signed accumulated sum; held until next `start`.
- `out_bit` output 1: neuron output; 1 when `acc` ≥ 0, else 0; held until next `start`.

## Operation
- Internal `mux_31` constants: `in10` = 7'b1111111 (−1), `in01` = 7'b0000001 (+1), `in00` = 7'b0000000 (0).
- Beat is accepted when `in_valid` && `in_ready`.
- Select encoding on an accepted beat:
  - `mask` = 1 → {sel1,sel0} = 00.
  - Else `x_bit` XNOR `w_bit` = 1 → 01 (+1).
  - Else → 10 (−1).
- With no accepted beat, {sel1,sel0} = 00. Select 11 is never driven.
- Accepted beat: `acc` ← `acc` + mux out, 7-bit wrap addition. No overflow is possible for `N_IN` ≤ 63. Beat counter increments; counter width is clog2(`N_IN`+1).
- FSM states: IDLE, ACC, DONE.
  - IDLE: `in_ready` = 0. `start` = 1 → `acc` ← 0, count ← 0, `out_bit` ← 0, go to ACC.
  - ACC: `in_ready` = 1. An accepted beat with count = `N_IN`−1 goes to DONE, and `out_bit` ← sign test of the updated `acc` on the same edge.
  - DONE: `in_ready` = 0, `done` = 1 for exactly this cycle. Unconditionally go to IDLE.
- `start` in ACC or DONE is ignored and has no effect on the count or `acc`.
- `in_valid` outside ACC is ignored. `x_bit`, `w_bit` and `mask` are don't-care there.
- Reset mid-evaluation: state → IDLE, partial sum discarded, no `done` pulse.

## Timing
- Reset values: state IDLE, `acc` 0, count 0, `out_bit` 0, `done` 0, `busy` 0, `in_ready` 0, {sel1,sel0} 00.
- `in_ready`, `busy` and `done` are decoded from registered state.
- {sel1,sel0} is combinational from the handshake and beat inputs in the same cycle.
- `acc` reflects beat k on the cycle after beat k is accepted.
- Latency, back-to-back beats: `start` at cycle 0; ACC from cycle 1; last beat at cycle `N_IN`; `done`, final `acc` and `out_bit` visible at cycle `N_IN`+1.
- Earliest next `start` is accepted at cycle `N_IN`+2 (IDLE).
- `in_valid` gaps stretch ACC one cycle per idle cycle; the result is unchanged.

## Test plan
- `N_IN`=32, all beats `x_bit`=`w_bit`=1, no gaps → `done` at cycle 33, `acc`=7'b0100000 (+32), `out_bit`=1, sel=01 on every beat.
- 32 beats with `x_bit`≠`w_bit` → `acc`=7'b1100000 (−32), `out_bit`=0, sel=10 on every beat.
- 32 beats alternating match/mismatch → `acc`=0, `out_bit`=1. Then 31 mismatches plus 1 masked beat → `acc`=−31, `out_bit`=0.
- Random `in_valid` gaps (50% duty), 16 matches and 16 mismatches → `acc`=0, `done` exactly once, sel=00 on every gap cycle.
- `start` pulsed at beat 10 and again during DONE → both ignored; final `acc` equals the no-pulse run; `done` single-cycle.
- `rst` at beat 20 → next cycle IDLE, `acc`=0, `busy`=0, no `done`. A fresh `start` then completes a normal 32-beat evaluation.
